// File: rtl/stack_frame_reverser_pkg.sv
// Shared definitions for the frame reverser: the FSM state type and the
// sizing helper for the stack occupancy count.
package stack_frame_reverser_pkg;

  // FILL accepts input words; DRAIN replays the buffered frame in reverse.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Width needed to hold an occupancy count from 0 up to and including depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_frame_reverser_lifo.sv
// lifo_stack: the team's standard register-array stack.
// Ports:
//   clk, rstn        rising-edge clock, synchronous active-low reset (count only)
//   push, pop        write data_in on top / discard top; ignored when full / empty
//   data_in          word to push
//   top              combinational read of the current top word ('0 when empty)
//   count            number of words held, 0..DEPTH
//   is_empty/is_full occupancy flags
module lifo_stack
  import stack_frame_reverser_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push,
  input  logic                           pop,
  input  logic [DATA_W-1:0]              data_in,
  output logic [DATA_W-1:0]              top,
  output logic [cnt_width(DEPTH)-1:0]    count,
  output logic                           is_empty,
  output logic                           is_full
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == CNT_W'(DEPTH));
    do_push  = push && !is_full;
    do_pop   = pop && !is_empty;
    wr_idx   = count[AW-1:0];
    rd_idx   = AW'(count - CNT_W'(1));
    top      = is_empty ? '0 : mem[rd_idx];
  end

  // Storage is intentionally not reset; only the occupancy count is.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/stack_frame_reverser.sv
// stack_frame_reverser: buffers each input frame in a LIFO stack and replays
// it in reverse order on the output stream.
// Ports:
//   clk, rstn                      rising-edge clock, synchronous active-low reset
//   in_valid/in_ready/in_data/in_last       input frame stream (valid/ready)
//   out_valid/out_ready/out_data/out_last   reversed frame stream (valid/ready)
//   overflow                       one-cycle pulse when a frame is split at DEPTH words
//   busy                           high while the reversed frame is being emitted
module stack_frame_reverser
  import stack_frame_reverser_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  state_t           state;
  state_t           state_next;
  logic             push;
  logic             pop;
  logic             push_fills;
  logic             overflow_q;
  logic             is_empty;
  logic             is_full;
  logic [CNT_W-1:0] count;
  logic [DATA_W-1:0] top;

  lifo_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .pop      (pop),
    .data_in  (in_data),
    .top      (top),
    .count    (count),
    .is_empty (is_empty),
    .is_full  (is_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A push that reaches DEPTH without in_last closes the
  // frame early; the rest of the source frame becomes the next frame.
  always_comb begin
    state_next = state;
    case (state)
      ST_FILL: begin
        if (push && (in_last || push_fills)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Output / handshake logic. Gated by rstn so that every handshake output
  // reads inactive while reset is held, regardless of the pre-reset state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    overflow  = 1'b0;
    if (rstn) begin
      case (state)
        ST_FILL: begin
          in_ready = !is_full;
        end
        ST_DRAIN: begin
          out_valid = !is_empty;
          out_last  = !is_empty && (count == CNT_W'(1));
          busy      = 1'b1;
        end
        default: ;
      endcase
      overflow = overflow_q;
    end
    out_data   = top;
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    push_fills = push && !in_last && (count == CNT_W'(DEPTH - 1));
  end

  // Overflow pulse lands in the first DRAIN cycle of a split frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_fills;
    end
  end

endmodule
